// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types, RV32I opcodes and control encodings for the multi-cycle sequencer
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JUMP   = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4
  } insn_cls_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  localparam logic [1:0] WB_PC4  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b10;

  localparam int MAX_WAIT_DEF = 15;

  // funct7[5] selects SUB only for register-register ops; shifts use it for both
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt,
                                                input logic is_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - combinational instruction decode: ALU controls, operand selects, class, illegal flag
module mc_decoder
  import mc_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [3:0]  o_alu_op,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic        o_br_un,
  output insn_cls_e   o_cls,
  output logic        o_illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_instr_bits;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_opa_sel = 1'b0;
    o_opb_sel = 1'b1;
    o_br_un   = 1'b0;
    o_cls     = CLS_ALU;
    o_illegal = 1'b0;
    case (opc)
      OPC_LUI:    o_alu_op = ALU_COPYB;
      OPC_AUIPC:  o_opa_sel = 1'b1;
      OPC_JAL: begin
        o_opa_sel = 1'b1;
        o_cls     = CLS_JUMP;
      end
      OPC_JALR:   o_cls = CLS_JUMP;
      // ALU forms the target PC+imm while the comparator decides
      OPC_BRANCH: begin
        o_opa_sel = 1'b1;
        o_cls     = CLS_BRANCH;
        o_br_un   = f3[1];
      end
      OPC_LOAD:   o_cls = CLS_LOAD;
      OPC_STORE:  o_cls = CLS_STORE;
      OPC_OP_IMM: o_alu_op = alu_from_funct(f3, i_instr[30], 1'b0);
      OPC_OP: begin
        o_opb_sel = 1'b0;
        o_alu_op  = alu_from_funct(f3, i_instr[30], 1'b1);
      end
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle RV32I control FSM with memory wait/timeout; PERF_CNT_EN adds cycle/instret counters
module multi_cycle_ctrl
  import mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_br_equal,
  input  logic        i_br_less,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_ir_wren,
  output logic        o_pc_wren,
  output logic        o_pc_sel,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_br_un,
  output logic [1:0]  o_wb_sel,
  output logic        o_rd_wren,
  output logic        o_insn_vld,
  output logic        o_fault,
  output logic [2:0]  o_state
`ifdef PERF_CNT_EN
  ,
  output logic [XLEN-1:0] o_cycle_cnt,
  output logic [XLEN-1:0] o_instret_cnt
`endif
);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;
  logic [3:0]        dec_alu_op;
  logic              dec_opa_sel, dec_opb_sel, dec_br_un, dec_illegal;
  insn_cls_e         dec_cls;
  logic              br_taken, waiting, timeout;

  mc_decoder u_dec (
    .i_instr   (i_instr),
    .o_alu_op  (dec_alu_op),
    .o_opa_sel (dec_opa_sel),
    .o_opb_sel (dec_opb_sel),
    .o_br_un   (dec_br_un),
    .o_cls     (dec_cls),
    .o_illegal (dec_illegal)
  );

  always_comb begin
    case (i_instr[14:12])
      3'b000:         br_taken = i_br_equal;
      3'b001:         br_taken = !i_br_equal;
      3'b100, 3'b110: br_taken = i_br_less;
      3'b101, 3'b111: br_taken = !i_br_less;
      default:        br_taken = 1'b0;
    endcase
  end

  assign waiting = ((state == ST_FETCH) && !i_imem_ack) || ((state == ST_MEM) && !i_dmem_ack);
  assign timeout = waiting && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // wait_cnt defaults to clear, so any ack or state change restarts the count
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_FETCH: begin
          if (i_imem_ack) begin
            state <= ST_DECODE;
          end else if (timeout) begin
            state   <= ST_TRAP;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state   <= ST_TRAP;
            fault_q <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (dec_cls)
            CLS_BRANCH:          state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            state <= (dec_cls == CLS_STORE) ? ST_FETCH : ST_WB;
          end else if (timeout) begin
            state   <= ST_TRAP;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: begin
          state   <= ST_TRAP;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // Write enables are masked while reset is asserted so an aborted instruction never commits
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_ir_wren  = 1'b0;
    o_pc_wren  = 1'b0;
    o_pc_sel   = 1'b0;
    o_opa_sel  = 1'b0;
    o_opb_sel  = 1'b0;
    o_alu_op   = ALU_ADD;
    o_br_un    = 1'b0;
    o_wb_sel   = WB_PC4;
    o_rd_wren  = 1'b0;
    o_insn_vld = 1'b0;
    o_fault    = fault_q;
    o_state    = state;
    if ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB)) begin
      o_opa_sel = dec_opa_sel;
      o_opb_sel = dec_opb_sel;
      o_alu_op  = dec_alu_op;
      o_br_un   = dec_br_un;
    end
    case (state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_wren  = i_imem_ack && i_reset;
      end
      ST_EXEC: begin
        if (dec_cls == CLS_BRANCH) begin
          o_pc_sel   = br_taken;
          o_pc_wren  = i_reset;
          o_insn_vld = i_reset;
        end
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (dec_cls == CLS_STORE);
        if (i_dmem_ack && (dec_cls == CLS_STORE)) begin
          o_pc_wren  = i_reset;
          o_insn_vld = i_reset;
        end
      end
      ST_WB: begin
        o_rd_wren  = i_reset;
        o_pc_wren  = i_reset;
        o_insn_vld = i_reset;
        o_pc_sel   = (dec_cls == CLS_JUMP);
        o_wb_sel   = (dec_cls == CLS_JUMP) ? WB_PC4 :
                     (dec_cls == CLS_LOAD) ? WB_LOAD : WB_ALU;
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_cycle_cnt   <= '0;
      o_instret_cnt <= '0;
    end else begin
      if (state != ST_TRAP) o_cycle_cnt <= o_cycle_cnt + XLEN'(1);
      if (o_insn_vld) o_instret_cnt <= o_instret_cnt + XLEN'(1);
    end
  end
`else
  logic [XLEN-1:0] unused_xlen;
  assign unused_xlen = '0;
`endif

endmodule
